reg_file_mp: RTL and testbench

Parametrised multi-port integer register file for the wider-issue light_rv32i cores. Provides RD_PORTS read ports and WR_PORTS write ports. Each register carries a scoreboard busy bit so issue logic can detect outstanding producers. Sits between decode/issue (reads, issue marking) and the writeback stage(s) (writes, busy clearing).

---
 rtl/reg_file_mp.sv | 116 +++++++++++
 tb/tb_reg_file_mp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with a per-register scoreboard busy bit.
// Reads are combinational, with optional same-cycle forwarding from the write ports.
// Writes, issue marking and flush all take effect on the rising clock edge.
// A write-port address collision is reported in a registered flag one cycle later.
module reg_file_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUMBER = 32,
    parameter int RD_PORTS   = 3,
    parameter int WR_PORTS   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] i_RdAddr,
    output logic [RD_PORTS*DATA_WIDTH-1:0] o_RdData,
    output logic [RD_PORTS-1:0]            o_RdBusy,
    input  logic [WR_PORTS-1:0]            i_WrEn,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] i_WrAddr,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] i_WrData,
    input  logic                           i_IssueEn,
    input  logic [ADDR_WIDTH-1:0]          i_IssueAddr,
    input  logic                           i_Flush,
    output logic                           o_WrConflict
);

    // Architectural state
    logic [DATA_WIDTH-1:0] reg_q [REG_NUMBER];
    logic [REG_NUMBER-1:0] busy_q;
    logic [REG_NUMBER-1:0] busy_d;
    logic                  conflict_q;
    logic                  conflict_d;

    // Per-register write resolution: which registers are written this cycle and with what.
    logic [REG_NUMBER-1:0] wr_hit;
    logic [DATA_WIDTH-1:0] wr_val [REG_NUMBER];

    // Resolve writes per register; scanning ports upward lets the highest index win.
    always_comb begin
        for (int r = 0; r < REG_NUMBER; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int p = 0; p < WR_PORTS; p++) begin
                if (r != 0 && i_WrEn[p] &&
                    i_WrAddr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = i_WrData[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Detect any pair of enabled write ports aiming at the same nonzero register.
    always_comb begin
        conflict_d = 1'b0;
        for (int p = 0; p < WR_PORTS; p++) begin
            for (int q = p + 1; q < WR_PORTS; q++) begin
                if (i_WrEn[p] && i_WrEn[q] &&
                    i_WrAddr[p*ADDR_WIDTH +: ADDR_WIDTH] == i_WrAddr[q*ADDR_WIDTH +: ADDR_WIDTH] &&
                    i_WrAddr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Scoreboard next state: a fresh issue outranks a retiring write; flush kills issue.
    genvar gi;
    generate
        for (gi = 0; gi < REG_NUMBER; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                assign busy_d[gi] = (i_IssueEn && !i_Flush && i_IssueAddr == ADDR_WIDTH'(gi)) ? 1'b1 :
                                    (wr_hit[gi] || i_Flush)                                    ? 1'b0 :
                                                                                                 busy_q[gi];
            end
        end
    endgenerate

    // Read ports: x0 is hardwired to zero/not busy; forwarded data is never reported busy.
    generate
        for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic                  rd_fwd;
            assign rd_addr = i_RdAddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign rd_fwd  = (BYPASS != 0) && wr_hit[rd_addr];
            assign o_RdData[gi*DATA_WIDTH +: DATA_WIDTH] = (rd_addr == '0) ? '0 :
                                                           rd_fwd          ? wr_val[rd_addr] :
                                                                             reg_q[rd_addr];
            assign o_RdBusy[gi] = (rd_addr != '0) && busy_q[rd_addr] && !rd_fwd;
        end
    endgenerate

    // State update; reset overrides every write, issue and flush in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < REG_NUMBER; r++) begin
                reg_q[r] <= '0;
            end
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int r = 0; r < REG_NUMBER; r++) begin
                if (wr_hit[r]) begin
                    reg_q[r] <= wr_val[r];
                end
            end
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign o_WrConflict = conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters, BYPASS=1).
// Directed steps followed by random traffic, all checked against a behavioural model.
module tb_reg_file_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int RP = 3;
    localparam int WP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [AW-1:0]     rd_addr [RP];
    logic [WP-1:0]     wr_en;
    logic [AW-1:0]     wr_addr [WP];
    logic [DW-1:0]     wr_data [WP];
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic              flush;

    logic [RP*AW-1:0]  rd_addr_bus;
    logic [RP*DW-1:0]  rd_data_bus;
    logic [RP-1:0]     rd_busy_bus;
    logic [WP*AW-1:0]  wr_addr_bus;
    logic [WP*DW-1:0]  wr_data_bus;
    logic              wr_conflict;

    assign rd_addr_bus = {rd_addr[2], rd_addr[1], rd_addr[0]};
    assign wr_addr_bus = {wr_addr[1], wr_addr[0]};
    assign wr_data_bus = {wr_data[1], wr_data[0]};

    reg_file_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUMBER(NR),
        .RD_PORTS(RP), .WR_PORTS(WP), .BYPASS(1)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .i_RdAddr    (rd_addr_bus),
        .o_RdData    (rd_data_bus),
        .o_RdBusy    (rd_busy_bus),
        .i_WrEn      (wr_en),
        .i_WrAddr    (wr_addr_bus),
        .i_WrData    (wr_data_bus),
        .i_IssueEn   (issue_en),
        .i_IssueAddr (issue_addr),
        .i_Flush     (flush),
        .o_WrConflict(wr_conflict)
    );

    // Reference model state
    logic [DW-1:0] m_mem  [NR];
    bit            m_busy [NR];
    bit            m_conf;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value a read of address a should see right now (forwarding included).
    task automatic model_read(input int a, output logic [DW-1:0] d, output logic b);
        bit hit = 0;
        logic [DW-1:0] v = '0;
        for (int p = 0; p < WP; p++) begin
            if (wr_en[p] && int'(wr_addr[p]) == a) begin
                hit = 1;
                v   = wr_data[p];
            end
        end
        if (a == 0) begin
            d = '0; b = 1'b0;
        end else begin
            d = hit ? v : m_mem[a];
            b = m_busy[a] && !hit;
        end
    endtask

    // Apply the effect of one clock edge to the model.
    task automatic model_edge();
        bit c = 0;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 0;
            end
            m_conf = 0;
        end else begin
            for (int p = 0; p < WP; p++)
                for (int q = p + 1; q < WP; q++)
                    if (wr_en[p] && wr_en[q] && wr_addr[p] == wr_addr[q] && wr_addr[p] != 0) c = 1;
            for (int p = 0; p < WP; p++) begin
                if (wr_en[p] && wr_addr[p] != 0) begin
                    m_mem[wr_addr[p]]  = wr_data[p];
                    m_busy[wr_addr[p]] = 0;
                end
            end
            if (flush) begin
                for (int r = 0; r < NR; r++) m_busy[r] = 0;
            end else if (issue_en && issue_addr != 0) begin
                m_busy[issue_addr] = 1;
            end
            m_conf = c;
        end
    endtask

    // One transaction: check outputs mid-cycle, clock, advance the model.
    task automatic cycle(input string tag);
        logic [DW-1:0] ed;
        logic          eb;
        #4;
        for (int k = 0; k < RP; k++) begin
            model_read(int'(rd_addr[k]), ed, eb);
            check($sformatf("%s_rd%0d_a%0d", tag, k, rd_addr[k]), rd_data_bus[k*DW +: DW], ed);
            check($sformatf("%s_busy%0d_a%0d", tag, k, rd_addr[k]), {31'b0, rd_busy_bus[k]}, {31'b0, eb});
        end
        check({tag, "_conflict"}, {31'b0, wr_conflict}, {31'b0, m_conf});
        $display("txn %-10s rd=%0d/%0d/%0d we=%b wa=%0d/%0d iss=%b@%0d fl=%b rst=%b",
                 tag, rd_addr[0], rd_addr[1], rd_addr[2], wr_en, wr_addr[0], wr_addr[1],
                 issue_en, issue_addr, flush, rst);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = '0; issue_en = 0; issue_addr = '0; flush = 0;
        for (int k = 0; k < RP; k++) rd_addr[k] = '0;
        for (int p = 0; p < WP; p++) begin
            wr_addr[p] = '0; wr_data[p] = '0;
        end
    endtask

    initial begin
        idle();
        rst = 1;
        for (int r = 0; r < NR; r++) begin
            m_mem[r] = '0; m_busy[r] = 0;
        end
        m_conf = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;

        // 1: every register on every port reads zero and not busy after reset
        for (int a = 0; a < NR; a++) begin
            for (int k = 0; k < RP; k++) rd_addr[k] = AW'(a);
            cycle("reset_rd");
        end

        // 2: same-cycle forwarding, then stored value
        idle();
        wr_en[0] = 1; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF; rd_addr[2] = 5;
        #1 check("fwd_x5", rd_data_bus[2*DW +: DW], 32'hDEADBEEF);
        cycle("wr_x5");
        idle(); rd_addr[2] = 5;
        cycle("rd_x5");

        // 3: write collision on x7 (port1 wins) and on x0 (no flag)
        idle();
        wr_en = 2'b11; wr_addr[0] = 7; wr_data[0] = 32'h11; wr_addr[1] = 7; wr_data[1] = 32'h22;
        cycle("coll_x7");
        idle(); rd_addr[0] = 7;
        #1 check("conf_set", {31'b0, wr_conflict}, 32'd1);
        cycle("after_x7");
        idle(); wr_en = 2'b11; wr_addr[0] = 0; wr_data[0] = 32'h1; wr_data[1] = 32'h2;
        cycle("coll_x0");
        idle();
        cycle("after_x0");

        // 4: issue x9, then retire it by a write
        idle(); issue_en = 1; issue_addr = 9;
        cycle("iss_x9");
        idle(); rd_addr[1] = 9;
        cycle("busy_x9");
        idle(); rd_addr[1] = 9; wr_en[1] = 1; wr_addr[1] = 9; wr_data[1] = 32'h33;
        cycle("wr_x9");
        idle(); rd_addr[1] = 9;
        cycle("free_x9");

        // 5: issue beats write on x3; flush beats issue on x4
        idle(); issue_en = 1; issue_addr = 3; wr_en[0] = 1; wr_addr[0] = 3; wr_data[0] = 32'h44;
        cycle("iss_wr_x3");
        idle(); rd_addr[0] = 3;
        #1 check("busy_x3", {31'b0, rd_busy_bus[0]}, 32'd1);
        cycle("chk_x3");
        idle(); flush = 1; issue_en = 1; issue_addr = 4; rd_addr[0] = 3; rd_addr[1] = 4;
        cycle("flush");
        idle(); rd_addr[0] = 3; rd_addr[1] = 4;
        cycle("post_flush");

        // 6: reset overrides a concurrent write and clears the scoreboard
        idle(); wr_en[0] = 1; wr_addr[0] = 10; wr_data[0] = 32'h55; issue_en = 1; issue_addr = 11;
        cycle("pre_rst");
        idle(); rst = 1; wr_en[0] = 1; wr_addr[0] = 10; wr_data[0] = 32'h66;
        cycle("rst_wr");
        idle(); rd_addr[0] = 10; rd_addr[1] = 11;
        #1 check("rst_x10", rd_data_bus[0 +: DW], 32'h0);
        cycle("post_rst");

        // Random traffic; narrow address range on some cycles to provoke collisions
        for (int n = 0; n < 400; n++) begin
            int span;
            idle();
            span = ($urandom_range(0, 3) == 0) ? 3 : NR - 1;
            for (int k = 0; k < RP; k++) rd_addr[k] = AW'($urandom_range(0, span));
            for (int p = 0; p < WP; p++) begin
                wr_en[p]   = $urandom_range(0, 1);
                wr_addr[p] = AW'($urandom_range(0, span));
                wr_data[p] = $urandom;
            end
            issue_en   = $urandom_range(0, 2) == 0;
            issue_addr = AW'($urandom_range(0, span));
            flush      = $urandom_range(0, 19) == 0;
            rst        = $urandom_range(0, 79) == 0;
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
